// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state encoding, the default program-size and
// base-address parameters, and the byte/word packing widths.
package loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam int unsigned        DEF_MAX_WORDS = 256;
    localparam logic [ADDR_W-1:0]  DEF_BASE_ADDR = 16'h0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CSUM    = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR over the data bytes of a load session.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr_i       - restart the accumulator at the start of a session
//   en_i        - fold data_i into the accumulator this cycle
//   data_i      - accepted data byte
//   cmp_i       - received checksum byte
//   match_c_o   - combinational: accumulator equals cmp_i
module loader_checksum
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic [BYTE_W-1:0] cmp_i,
    output logic              match_c_o
);

    logic [BYTE_W-1:0] acc_q;

    // Accumulator: clear wins over accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign match_c_o = (acc_q == cmp_i);

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: receives a big-endian 16-bit word count,
// then that many big-endian 16-bit instruction words, and writes them to
// instruction memory starting at BASE_ADDR while holding the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   load_start          - begin a session (honoured only in IDLE)
//   rx_valid/rx_data    - byte source; transfer when rx_valid & rx_ready
//   rx_ready            - loader accepts a byte this cycle
//   im_wren/im_address/im_data - instruction-memory write port
//   cpu_hold            - CPU held in reset while a session is active
//   load_done           - one-cycle pulse on successful completion
//   load_error          - sticky error, cleared by the next load_start
//   word_count          - words written in the current/last session
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned       MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              im_wren,
    output logic [ADDR_W-1:0] im_address,
    output logic [WORD_W-1:0] im_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [WORD_W-1:0] word_count
);

    localparam int unsigned        CNT_W       = WORD_W + 1;
    localparam logic [CNT_W-1:0]   MAX_WORDS_L = CNT_W'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_ST = CSUM;
`else
    localparam state_e END_ST = DONE;
`endif

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [BYTE_W-1:0]   hi_byte_q, hi_byte_d;
    logic                wr_pend_q, wr_pend_d;
    logic [WORD_W-1:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0]   im_address_q, im_address_d;
    logic [WORD_W-1:0]   im_data_q, im_data_d;
    logic                im_wren_q, im_wren_d;
    logic                rx_ready_q, rx_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_error_q, load_error_d;

    logic                xfer_c;
    logic [WORD_W-1:0]   len_rx_c;

    assign xfer_c   = rx_valid & rx_ready_q;
    assign len_rx_c = {len_q[WORD_W-1:BYTE_W], rx_data};

`ifdef LOADER_CHECKSUM_EN
    logic csum_clr_c;
    logic csum_en_c;
    logic csum_match_c;

    assign csum_clr_c = (state_q == IDLE) & load_start;
    assign csum_en_c  = xfer_c & ((state_q == DATA_HI) | (state_q == DATA_LO));

    loader_checksum u_checksum (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (csum_clr_c),
        .en_i      (csum_en_c),
        .data_i    (rx_data),
        .cmp_i     (rx_data),
        .match_c_o (csum_match_c)
    );
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_byte_d    = hi_byte_q;
        wr_pend_d    = wr_pend_q;
        word_count_d = word_count_q;
        im_address_d = im_address_q;
        im_data_d    = im_data_q;
        im_wren_d    = 1'b0;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        rx_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d      = LEN_HI;
                    cpu_hold_d   = 1'b1;
                    word_count_d = '0;
                    load_error_d = 1'b0;
                end
            end
            LEN_HI: begin
                if (xfer_c) begin
                    len_d   = {rx_data, len_q[BYTE_W-1:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer_c) begin
                    len_d = len_rx_c;
                    if ({1'b0, len_rx_c} > MAX_WORDS_L) begin
                        load_error_d = 1'b1;
                        cpu_hold_d   = 1'b0;
                        state_d      = IDLE;
                    end else if (len_rx_c == '0) begin
                        state_d = END_ST;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer_c) begin
                    hi_byte_d = rx_data;
                    state_d   = DATA_LO;
                end
            end
            DATA_LO: begin
                if (wr_pend_q) begin
                    // Write cycle: word_count_q already holds the new count
                    wr_pend_d = 1'b0;
                    state_d   = (word_count_q < len_q) ? DATA_HI : END_ST;
                end else if (xfer_c) begin
                    im_data_d    = {hi_byte_q, rx_data};
                    im_address_d = BASE_ADDR + word_count_q;
                    im_wren_d    = 1'b1;
                    word_count_d = word_count_q + WORD_W'(1);
                    wr_pend_d    = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer_c) begin
                    if (csum_match_c) begin
                        state_d = DONE;
                    end else begin
                        load_error_d = 1'b1;
                        cpu_hold_d   = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
`else
            CSUM: begin
                state_d = IDLE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // DONE is only ever entered from another state, so this fires once
        if (state_d == DONE) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
        end

        rx_ready_d = (state_d == LEN_HI) | (state_d == LEN_LO) |
                     (state_d == DATA_HI) | (state_d == CSUM) |
                     ((state_d == DATA_LO) & ~wr_pend_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            hi_byte_q    <= '0;
            wr_pend_q    <= 1'b0;
            word_count_q <= '0;
            im_address_q <= '0;
            im_data_q    <= '0;
            im_wren_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_byte_q    <= hi_byte_d;
            wr_pend_q    <= wr_pend_d;
            word_count_q <= word_count_d;
            im_address_q <= im_address_d;
            im_data_q    <= im_data_d;
            im_wren_q    <= im_wren_d;
            rx_ready_q   <= rx_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign im_wren    = im_wren_q;
    assign im_address = im_address_q;
    assign im_data    = im_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (default parameters).
// Expected memory writes are queued by the stimulus; a negedge monitor
// pops and compares on every im_wren. Define LOADER_CHECKSUM_EN to also
// send checksum bytes and run the bad-checksum case.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_wren;
    logic [15:0] im_address;
    logic [15:0] im_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  errors   = 0;
    int  checks   = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;

    instr_mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .im_wren    (im_wren),
        .im_address (im_address),
        .im_data    (im_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (load_done === 1'b1) done_cnt++;
        if (im_wren === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h@%0h expected none", im_data, im_address);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write", {im_address, im_data}, {mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // Offer one byte until it transfers; rnd toggles rx_valid randomly
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit done_b = 1'b0;
        int guard  = 0;
        while (!done_b) begin
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_data  = b;
            @(negedge clk);
            if (rx_valid && rx_ready) done_b = 1'b1;
            @(posedge clk); #1;
            guard++;
            if (!done_b && guard > 200) begin
                chk("byte_timeout", 32'(guard), 32'd0);
                done_b = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    int wr0, dn0;

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        load_start = 1'b1;           // reset must dominate
        @(negedge clk);
        chk("rst_rx_ready",   32'(rx_ready), 32'd0);
        chk("rst_im_wren",    32'(im_wren), 32'd0);
        chk("rst_cpu_hold",   32'(cpu_hold), 32'd0);
        chk("rst_load_done",  32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_im_address", 32'(im_address), 32'd0);
        chk("rst_im_data",    32'(im_data), 32'd0);
        @(posedge clk); #1;
        load_start = 1'b0;
        reset      = 1'b0;
        @(posedge clk); #1;

        // Two-word load
        wr0 = wr_cnt; dn0 = done_cnt;
        push(16'h0000, 16'h1234);
        push(16'h0001, 16'hABCD);
        pulse_start();
        @(negedge clk);
        chk("t1_cpu_hold_on", 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0); send_byte(8'hCD, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h40, 1'b0);      // 12^34^AB^CD
`endif
        wait_done(20);
        @(negedge clk);
        chk("t1_word_count", 32'(word_count), 32'd2);
        chk("t1_cpu_hold_off", 32'(cpu_hold), 32'd0);
        chk("t1_rx_ready_idle", 32'(rx_ready), 32'd0);
        chk("t1_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("t1_done_pulses", 32'(done_cnt - dn0), 32'd1);
        chk("t1_no_error", 32'(load_error), 32'd0);
        @(posedge clk); #1;

        // Oversize length 0x0101 > 256
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start();
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
        @(negedge clk);
        chk("t2_load_error", 32'(load_error), 32'd1);
        chk("t2_rx_ready", 32'(rx_ready), 32'd0);
        chk("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_writes", 32'(wr_cnt - wr0), 32'd0);
        chk("t2_done", 32'(done_cnt - dn0), 32'd0);
        @(posedge clk); #1;

        // Four words, random rx_valid, stray load_start mid-load
        wr0 = wr_cnt; dn0 = done_cnt;
        push(16'h0000, 16'h0001);
        push(16'h0001, 16'hFFFE);
        push(16'h0002, 16'h5A5A);
        push(16'h0003, 16'h8000);
        pulse_start();
        @(negedge clk);
        chk("t3_error_cleared", 32'(load_error), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        pulse_start();
        send_byte(8'hFE, 1'b1);
        send_byte(8'h5A, 1'b1); send_byte(8'h5A, 1'b1);
        send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80, 1'b1);
`endif
        wait_done(20);
        @(negedge clk);
        chk("t3_word_count", 32'(word_count), 32'd4);
        chk("t3_writes", 32'(wr_cnt - wr0), 32'd4);
        chk("t3_done_pulses", 32'(done_cnt - dn0), 32'd1);
        @(posedge clk); #1;

        // Reset right after the first write of a three-word load
        wr0 = wr_cnt;
        push(16'h0000, 16'h1122);
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        reset = 1'b1;                // write cycle is in progress now
        @(negedge clk);
        @(negedge clk);
        chk("t4_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t4_rst_word_count", 32'(word_count), 32'd0);
        chk("t4_rst_im_wren", 32'(im_wren), 32'd0);
        chk("t4_rst_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        repeat (4) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("t4_one_write", 32'(wr_cnt - wr0), 32'd1);
        push(16'h0000, 16'h7788);
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hFF, 1'b0);
`endif
        wait_done(20);
        @(negedge clk);
        chk("t4_restart_count", 32'(word_count), 32'd1);
        @(posedge clk); #1;

        // Zero-length program
        wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_done(10);
        @(negedge clk);
        chk("t5_word_count", 32'(word_count), 32'd0);
        chk("t5_writes", 32'(wr_cnt - wr0), 32'd0);
        chk("t5_done_pulses", 32'(done_cnt - dn0), 32'd1);
        @(posedge clk); #1;

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: XOR of 00 FF is FF, 00 sent
        wr0 = wr_cnt; dn0 = done_cnt;
        push(16'h0000, 16'h00FF);
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        chk("t6_load_error", 32'(load_error), 32'd1);
        chk("t6_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("t6_no_done", 32'(done_cnt - dn0), 32'd0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
